// File: rtl/qam_slicer.sv
`default_nettype none
// ============================================================================
// Module   : qam_slicer
// Brief    : 16-QAM symbol slicer. Integrates 2^SPS_LOG2 demodulator samples
//            per axis, decides Gray-coded 2-bit levels, buffers 4-bit symbols.
// Revision : 1.0 - initial release
// ============================================================================
module qam_slicer #(
    parameter int                 SPS_LOG2   = 3,
    parameter logic signed [17:0] THRESH     = 18'sd8192,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic               axi_clk,
    input  logic               axi_rst,
    input  logic               demult_valid,
    input  logic signed [17:0] demult_i,
    input  logic signed [17:0] demult_q,
    input  logic               sym_align,
    output logic               dout_valid,
    output logic [3:0]         dout,
    input  logic               dout_ready,
    output logic               overflow
);

    localparam int c_acc_w = 18 + SPS_LOG2;
    localparam int c_cnt_w = (SPS_LOG2 > 0) ? SPS_LOG2 : 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'((1 << SPS_LOG2) - 1);
    localparam logic [c_ptr_w:0]   c_full    = FIFO_DEPTH[c_ptr_w:0];

    logic [c_cnt_w-1:0]        r_count;
    logic                      r_align_pend;
    logic signed [c_acc_w-1:0] r_acc_i;
    logic signed [c_acc_w-1:0] r_acc_q;

    logic [c_cnt_w-1:0]        w_cnt_eff;
    logic                      w_first;
    logic                      w_last;
    logic signed [c_acc_w-1:0] w_i_ext;
    logic signed [c_acc_w-1:0] w_q_ext;
    logic signed [c_acc_w-1:0] w_i_tot;
    logic signed [c_acc_w-1:0] w_q_tot;
    logic signed [c_acc_w-1:0] w_i_shift;
    logic signed [c_acc_w-1:0] w_q_shift;
    logic signed [17:0]        w_i_avg;
    logic signed [17:0]        w_q_avg;
    logic [3:0]                w_sym;
    logic                      w_push;

    // Gray mapping of one averaged axis onto the four amplitude levels
    function automatic logic [1:0] slice_axis(input logic signed [17:0] a);
        if (a >= THRESH)
            slice_axis = 2'b10;
        else if (a >= 18'sd0)
            slice_axis = 2'b11;
        else if (a >= -THRESH)
            slice_axis = 2'b01;
        else
            slice_axis = 2'b00;
    endfunction

    // An alignment pulse (now or pending) restarts the symbol at this sample
    assign w_cnt_eff = (sym_align || r_align_pend) ? '0 : r_count;
    assign w_first   = (w_cnt_eff == '0);
    assign w_last    = (w_cnt_eff == c_cnt_max);

    assign w_i_ext   = demult_i;
    assign w_q_ext   = demult_q;
    assign w_i_tot   = w_first ? w_i_ext : (r_acc_i + w_i_ext);
    assign w_q_tot   = w_first ? w_q_ext : (r_acc_q + w_q_ext);
    assign w_i_shift = w_i_tot >>> SPS_LOG2;
    assign w_q_shift = w_q_tot >>> SPS_LOG2;
    assign w_i_avg   = w_i_shift[17:0];
    assign w_q_avg   = w_q_shift[17:0];
    assign w_sym     = {slice_axis(w_i_avg), slice_axis(w_q_avg)};
    assign w_push    = demult_valid && w_last;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_count      <= '0;
            r_align_pend <= 1'b0;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
        end else begin
            if (demult_valid) begin
                r_count      <= w_last ? '0 : (w_cnt_eff + 1'b1);
                r_align_pend <= 1'b0;
                r_acc_i      <= w_i_tot;
                r_acc_q      <= w_q_tot;
            end else if (sym_align) begin
                r_align_pend <= 1'b1;
            end
        end
    end

    // Output symbol FIFO
    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_occ;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == c_full);
    assign w_pop   = !w_empty && dout_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge axi_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_sym;
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_push && !w_wr)
                r_overflow <= 1'b1;
        end
    end

    assign dout_valid = !w_empty;
    assign dout       = w_empty ? 4'b0000 : r_mem[r_rd_ptr];
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qam_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_slicer
// Brief    : Directed self-checking bench for qam_slicer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_slicer;

    logic               axi_clk      = 1'b0;
    logic               axi_rst      = 1'b1;
    logic               demult_valid = 1'b0;
    logic signed [17:0] demult_i     = '0;
    logic signed [17:0] demult_q     = '0;
    logic               sym_align    = 1'b0;
    logic               dout_ready   = 1'b0;
    logic               dout_valid;
    logic [3:0]         dout;
    logic               overflow;

    int n_assert = 0;
    int n_fail   = 0;

    qam_slicer dut (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .demult_valid (demult_valid),
        .demult_i     (demult_i),
        .demult_q     (demult_q),
        .sym_align    (sym_align),
        .dout_valid   (dout_valid),
        .dout         (dout),
        .dout_ready   (dout_ready),
        .overflow     (overflow)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic signed [17:0] i, input logic signed [17:0] q, input logic align);
        @(negedge axi_clk);
        demult_valid = 1'b1;
        demult_i     = i;
        demult_q     = q;
        sym_align    = align;
    endtask

    task automatic idle();
        @(negedge axi_clk);
        demult_valid = 1'b0;
        sym_align    = 1'b0;
    endtask

    task automatic send_sym(input logic signed [17:0] i, input logic signed [17:0] q);
        repeat (8) drive(i, q, 1'b0);
    endtask

    // Boundary vectors and distinct-symbol table
    logic signed [17:0] bi [3] = '{18'sd8192, -18'sd8192, 18'sd8191};
    logic signed [17:0] bq [3] = '{18'sd0, -18'sd8193, -18'sd1};
    logic [3:0]         bx [3] = '{4'b1011, 4'b0100, 4'b1101};
    logic signed [17:0] fi [5] = '{18'sd12288, 18'sd4096, -18'sd4096, -18'sd12288, 18'sd12288};
    logic signed [17:0] fq [5] = '{18'sd12288, 18'sd4096, -18'sd4096, -18'sd12288, -18'sd12288};
    logic [3:0]         fx [5] = '{4'b1010, 4'b1111, 4'b0101, 4'b0000, 4'b1000};

    initial begin
        repeat (3) @(negedge axi_clk);
        chk("rst_valid", 8'(dout_valid), 8'd0);
        chk("rst_dout",  8'(dout), 8'd0);
        chk("rst_ovf",   8'(overflow), 8'd0);
        axi_rst    = 1'b0;
        dout_ready = 1'b1;

        // Basic symbol and its one-cycle latency
        for (int k = 0; k < 8; k++) begin
            drive(18'sd12288, -18'sd4096, 1'b0);
            chk("basic_early", 8'(dout_valid), 8'd0);
        end
        idle();
        chk("basic_valid", 8'(dout_valid), 8'd1);
        chk("basic_dout",  8'(dout), 8'(4'b1001));
        idle();
        chk("basic_pop", 8'(dout_valid), 8'd0);

        // Decision thresholds
        for (int j = 0; j < 3; j++) begin
            send_sym(bi[j], bq[j]);
            idle();
            chk("bound_valid", 8'(dout_valid), 8'd1);
            chk("bound_dout",  8'(dout), 8'(bx[j]));
            idle();
            chk("bound_pop", 8'(dout_valid), 8'd0);
        end

        // Overflow with stalled consumer
        dout_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            send_sym(fi[j], fq[j]);
            idle();
            chk("ovf_flag", 8'(overflow), 8'(j == 4));
            chk("ovf_head", 8'(dout), 8'(fx[0]));
        end
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_drain_valid", 8'(dout_valid), 8'd1);
            chk("ovf_drain_dout",  8'(dout), 8'(fx[k]));
            @(negedge axi_clk);
        end
        chk("ovf_empty",  8'(dout_valid), 8'd0);
        chk("ovf_sticky", 8'(overflow), 8'd1);

        @(negedge axi_clk);
        axi_rst = 1'b1;
        @(negedge axi_clk);
        chk("rst2_ovf", 8'(overflow), 8'd0);
        axi_rst = 1'b0;

        // Simultaneous push and pop while full
        dout_ready = 1'b0;
        for (int j = 0; j < 4; j++) send_sym(fi[j], fq[j]);
        repeat (7) drive(fi[4], fq[4], 1'b0);
        drive(fi[4], fq[4], 1'b0);
        dout_ready = 1'b1;
        chk("full_head", 8'(dout), 8'(fx[0]));
        for (int k = 1; k < 5; k++) begin
            idle();
            chk("full_valid", 8'(dout_valid), 8'd1);
            chk("full_dout",  8'(dout), 8'(fx[k]));
        end
        idle();
        chk("full_empty", 8'(dout_valid), 8'd0);
        chk("full_ovf",   8'(overflow), 8'd0);

        // Alignment together with a valid sample
        repeat (3) drive(-18'sd12288, 18'sd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(18'sd4096, 18'sd0, k == 0);
            chk("align_early", 8'(dout_valid), 8'd0);
        end
        idle();
        chk("align_valid", 8'(dout_valid), 8'd1);
        chk("align_dout",  8'(dout), 8'(4'b1111));
        idle();
        chk("align_single", 8'(dout_valid), 8'd0);

        // Alignment pulse on an idle cycle
        repeat (3) drive(-18'sd12288, 18'sd0, 1'b0);
        @(negedge axi_clk);
        demult_valid = 1'b0;
        sym_align    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(18'sd12288, 18'sd0, 1'b0);
            chk("align2_early", 8'(dout_valid), 8'd0);
        end
        idle();
        chk("align2_dout", 8'(dout), 8'(4'b1011));
        idle();
        chk("align2_single", 8'(dout_valid), 8'd0);

        // Asynchronous reset mid-symbol with buffered data
        dout_ready = 1'b0;
        send_sym(18'sd12288, 18'sd12288);
        send_sym(18'sd4096, 18'sd4096);
        repeat (5) drive(-18'sd4096, 18'sd4096, 1'b0);
        idle();
        chk("arst_pre_valid", 8'(dout_valid), 8'd1);
        #2 axi_rst = 1'b1;
        #1;
        chk("arst_valid", 8'(dout_valid), 8'd0);
        chk("arst_dout",  8'(dout), 8'd0);
        @(negedge axi_clk);
        axi_rst    = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(18'sd4096, -18'sd12288, 1'b0);
            chk("arst_early", 8'(dout_valid), 8'd0);
        end
        idle();
        chk("arst_sym_valid", 8'(dout_valid), 8'd1);
        chk("arst_sym_dout",  8'(dout), 8'(4'b1100));
        idle();
        chk("arst_single", 8'(dout_valid), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qam_slicer.md
QAM_SLICER -- requirements
Module: qam_slicer

Interface
REQ-001 Parameter SPS_LOG2, default 3, log2 of demodulator samples per symbol; legal range 0..4.
REQ-002 Parameter THRESH, default 18'sd8192 (2.0 in 5Q12), outer/inner decision threshold magnitude; always positive.
REQ-003 Parameter FIFO_DEPTH, default 4, output symbol buffer depth; power of two, at least 2.
REQ-004 axi_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 axi_rst  input  1  asynchronous, active-high reset.
REQ-006 demult_valid  input  1  one demodulated sample present this cycle; no backpressure toward the demodulator.
REQ-007 demult_i  input  18  signed in-phase sample, 5Q12.
REQ-008 demult_q  input  18  signed quadrature sample, 5Q12.
REQ-009 sym_align  input  1  single-cycle pulse marking the current or next accepted sample as the first of a symbol.
REQ-010 dout_valid  output  1  buffered symbol available.
REQ-011 dout  output  4  decided symbol {i_bits[1:0], q_bits[1:0]}.
REQ-012 dout_ready  input  1  consumer accepts dout when high together with dout_valid.
REQ-013 overflow  output  1  sticky flag: a decided symbol was dropped because the FIFO was full.

Function
REQ-014 A sample shall be accepted on every cycle with demult_valid=1; there is no other input qualification.
REQ-015 The slicer shall keep a sample counter 0..2^SPS_LOG2-1 and two signed accumulators, 18+SPS_LOG2 bits each, sign-extending the inputs.
REQ-016 On an accepted sample with counter=0, the accumulators shall load the sample; otherwise they shall add the sample.
REQ-017 On an accepted sample with counter=2^SPS_LOG2-1, the symbol shall complete, the counter shall wrap to 0, and the total shall include that sample.
REQ-018 The average shall be total >>> SPS_LOG2 (arithmetic shift, truncation toward minus infinity), 18 bits, computed per axis.
REQ-019 Per-axis decision: avg >= THRESH gives 2'b10; 0 <= avg < THRESH gives 2'b11; -THRESH <= avg < 0 gives 2'b01; avg < -THRESH gives 2'b00 (Gray).
REQ-020 The decided 4-bit symbol shall be pushed into the FIFO at the clock edge that accepts the final sample; dout_valid shall therefore rise in the next cycle when the FIFO was empty.
REQ-021 sym_align=1 with demult_valid=1 shall treat that sample as counter=0 (load, discard partial sum); sym_align=1 without a valid sample shall force the counter to 0 for the next accepted sample.
REQ-022 When SPS_LOG2=0, every accepted sample shall be a complete symbol.
REQ-023 The FIFO shall be first-in first-out; dout shall show the head entry whenever dout_valid=1 and hold it stable until popped.
REQ-024 A pop shall occur when dout_valid and dout_ready are both 1.
REQ-025 A push when the FIFO is full and no pop occurs shall drop the new symbol, leave the contents unchanged, and set overflow.
REQ-026 A push and a pop in the same cycle when full shall both succeed with no overflow; occupancy stays FIFO_DEPTH.
REQ-027 A push and a pop in the same cycle at any other occupancy shall leave occupancy unchanged.
REQ-028 overflow shall remain set until reset.

Reset
REQ-029 While axi_rst=1: dout_valid=0, dout=4'b0000, overflow=0, FIFO empty, counter=0, accumulators=0.
REQ-030 Assertion mid-symbol or with the FIFO non-empty shall discard all partial and buffered data immediately, without waiting for a clock edge.
REQ-031 The first accepted sample after deassertion shall be counter=0.

Verification
REQ-032 SPS_LOG2=3, 8 samples I=12288, Q=-4096, dout_ready=1 -> one symbol dout=4'b1001, dout_valid high exactly 1 cycle after the 8th sample edge.
REQ-033 Boundary: 8 samples each of (I=8192,Q=0), then (I=-8192,Q=-8193), then (I=8191,Q=-1) -> dout 4'b1011, 4'b0100, 4'b1101.
REQ-034 dout_ready=0, 5 complete symbols of distinct values -> the first 4 are held, overflow=1 after the 5th; raising dout_ready pops the first 4 in order.
REQ-035 FIFO full with dout_ready=1 in the cycle a 5th symbol completes -> no overflow, all 5 symbols delivered in order.
REQ-036 3 samples of I=-12288, then sym_align with 8 samples of I=4096 -> a single symbol with i_bits=2'b11; the partial sum is discarded.
REQ-037 axi_rst pulsed after 5 of 8 samples, with 2 symbols buffered -> dout_valid=0 immediately; the next 8 samples yield exactly one correct symbol.
